// File: rtl/exec_stage_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch conditions and the
// multiply/divide sequencer state type.
package exec_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_XOR  = 4'h3,
        ALU_OR   = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_MUL  = 4'h8,
        ALU_DIVU = 4'h9,
        ALU_REMU = 4'hA
    } alu_op_e;

    localparam logic [3:0] COND_ALWAYS = 4'h0;
    localparam logic [3:0] COND_LE     = 4'h1;
    localparam logic [3:0] COND_L      = 4'h2;
    localparam logic [3:0] COND_E      = 4'h3;
    localparam logic [3:0] COND_NE     = 4'h4;
    localparam logic [3:0] COND_GE     = 4'h5;
    localparam logic [3:0] COND_G      = 4'h6;
    localparam logic [3:0] COND_NONE   = 4'hF;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/exec_stage_md_unit.sv
// Iterative multiply / unsigned divide: one shift-add or restoring
// shift-subtract step per cycle, operands captured at start.
module md_unit
    import exec_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(MD_CYCLES) + 1;

    md_state_e       state_r, state_nx;
    logic [3:0]      op_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] a_r, b_r, acc_r;
    logic [XLEN-1:0] a_step, b_step, acc_step;
    logic [XLEN:0]   rem_sh;
    logic            div_zero, last_step;

    assign div_zero  = (op != ALU_MUL) && (b == {XLEN{1'b0}});
    assign last_step = (cnt_r == CW'(MD_CYCLES - 1));
    // a_r holds the quotient for divides; acc_r holds product or remainder
    assign result    = (op_r == ALU_DIVU) ? a_r : acc_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= MD_IDLE;
        else       state_r <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx = state_r;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (flush) begin
                    state_nx = MD_IDLE;
                end else if (start) begin
                    busy     = 1'b1;
                    state_nx = div_zero ? MD_DONE : MD_RUN;
                end else begin
                    state_nx = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (flush) begin
                    state_nx = MD_IDLE;
                end else begin
                    busy     = 1'b1;
                    state_nx = last_step ? MD_DONE : MD_RUN;
                end
            end
            MD_DONE: begin
                done     = ~flush;
                state_nx = MD_IDLE;
            end
            default: state_nx = MD_IDLE;
        endcase
    end

    // One iteration of the selected algorithm
    always_comb begin
        rem_sh = {acc_r, a_r[XLEN-1]};
        if (op_r == ALU_MUL) begin
            acc_step = b_r[0] ? (acc_r + a_r) : acc_r;
            a_step   = a_r << 1;
            b_step   = b_r >> 1;
        end else if (rem_sh >= {1'b0, b_r}) begin
            acc_step = XLEN'(rem_sh - {1'b0, b_r});
            a_step   = {a_r[XLEN-2:0], 1'b1};
            b_step   = b_r;
        end else begin
            acc_step = rem_sh[XLEN-1:0];
            a_step   = {a_r[XLEN-2:0], 1'b0};
            b_step   = b_r;
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r  <= 4'h0;
            cnt_r <= {CW{1'b0}};
            a_r   <= {XLEN{1'b0}};
            b_r   <= {XLEN{1'b0}};
            acc_r <= {XLEN{1'b0}};
        end else if (state_r == MD_IDLE && start && !flush) begin
            op_r  <= op;
            cnt_r <= {CW{1'b0}};
            b_r   <= b;
            if (div_zero) begin
                a_r   <= {XLEN{1'b1}};
                acc_r <= a;
            end else begin
                a_r   <= a;
                acc_r <= {XLEN{1'b0}};
            end
        end else if (state_r == MD_RUN) begin
            cnt_r <= cnt_r + CW'(1);
            a_r   <= a_step;
            b_r   <= b_step;
            acc_r <= acc_step;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU, condition flags and branch condition,
// with multi-cycle multiply/divide that stalls the upstream pipeline.
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      d_aluc,
    input  logic [3:0]      d_jmp,
    input  logic [XLEN-1:0] d_imm,
    input  logic [XLEN-1:0] ra_val,
    input  logic [XLEN-1:0] rb_val,
    input  logic            d_useimm,
    input  logic            d_setcond,
    input  logic            d_wreg,
    input  logic            d_wmem,
    input  logic            d_m2reg,
    input  logic [4:0]      d_rn,
    input  logic            e_flush,
    output logic [XLEN-1:0] e_result,
    output logic [XLEN-1:0] e_store_data,
    output logic            e_cnd,
    output logic [4:0]      e_rn,
    output logic            e_wreg,
    output logic            e_wmem,
    output logic            e_m2reg,
    output logic            e_stall
);
    logic [XLEN-1:0] opb, md_result;
    logic            md_busy, md_done, of_s;
    logic            zf_r, sf_r, of_r;

    assign opb = d_useimm ? d_imm : rb_val;

    md_unit #(.XLEN(XLEN), .MD_CYCLES(MD_CYCLES)) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (is_md_op(d_aluc)),
        .flush  (e_flush),
        .op     (d_aluc),
        .a      (ra_val),
        .b      (opb),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // While reset is held no operation may start, so no stall is requested
    assign e_stall      = md_busy & ~reset;
    assign e_store_data = rb_val;
    assign e_rn         = d_rn;
    assign e_m2reg      = d_m2reg;
    assign e_wreg       = d_wreg & ~e_stall & ~e_flush;
    assign e_wmem       = d_wmem & ~e_stall & ~e_flush;

    // ALU result and signed overflow
    always_comb begin
        e_result = {XLEN{1'b0}};
        of_s     = 1'b0;
        case (d_aluc)
            ALU_ADD: begin
                e_result = ra_val + opb;
                of_s = (ra_val[XLEN-1] == opb[XLEN-1]) && (e_result[XLEN-1] != ra_val[XLEN-1]);
            end
            ALU_SUB: begin
                e_result = ra_val - opb;
                of_s = (ra_val[XLEN-1] != opb[XLEN-1]) && (e_result[XLEN-1] != ra_val[XLEN-1]);
            end
            ALU_AND:  e_result = ra_val & opb;
            ALU_XOR:  e_result = ra_val ^ opb;
            ALU_OR:   e_result = ra_val | opb;
            ALU_SLL:  e_result = ra_val << opb[4:0];
            ALU_SRL:  e_result = ra_val >> opb[4:0];
            ALU_SRA:  e_result = $signed(ra_val) >>> opb[4:0];
            ALU_MUL, ALU_DIVU, ALU_REMU: e_result = md_done ? md_result : {XLEN{1'b0}};
            default:  e_result = {XLEN{1'b0}};
        endcase
    end

    // Condition flags, written only by a retiring setcond instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zf_r <= 1'b1;
            sf_r <= 1'b0;
            of_r <= 1'b0;
        end else if (d_setcond && !e_stall && !e_flush) begin
            zf_r <= (e_result == {XLEN{1'b0}});
            sf_r <= e_result[XLEN-1];
            of_r <= of_s;
        end else begin
            zf_r <= zf_r;
        end
    end

    // Branch condition from the stored flags
    always_comb begin
        e_cnd = 1'b0;
        case (d_jmp)
            COND_ALWAYS: e_cnd = 1'b1;
            COND_LE:     e_cnd = (sf_r ^ of_r) | zf_r;
            COND_L:      e_cnd = sf_r ^ of_r;
            COND_E:      e_cnd = zf_r;
            COND_NE:     e_cnd = ~zf_r;
            COND_GE:     e_cnd = ~(sf_r ^ of_r);
            COND_G:      e_cnd = ~(sf_r ^ of_r) & ~zf_r;
            COND_NONE:   e_cnd = 1'b1;
            default:     e_cnd = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: a table of single-cycle ALU vectors plus
// hand-written multi-cycle, flush and reset sequences.
module tb_exec_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  d_aluc, d_jmp;
    logic [31:0] d_imm, ra_val, rb_val;
    logic        d_useimm, d_setcond, d_wreg, d_wmem, d_m2reg;
    logic [4:0]  d_rn;
    logic        e_flush;
    logic [31:0] e_result, e_store_data;
    logic        e_cnd, e_wreg, e_wmem, e_m2reg, e_stall;
    logic [4:0]  e_rn;

    int nvec  = 0;
    int nfail = 0;

    exec_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .d_aluc(d_aluc), .d_jmp(d_jmp), .d_imm(d_imm),
        .ra_val(ra_val), .rb_val(rb_val), .d_useimm(d_useimm), .d_setcond(d_setcond),
        .d_wreg(d_wreg), .d_wmem(d_wmem), .d_m2reg(d_m2reg), .d_rn(d_rn),
        .e_flush(e_flush), .e_result(e_result), .e_store_data(e_store_data),
        .e_cnd(e_cnd), .e_rn(e_rn), .e_wreg(e_wreg), .e_wmem(e_wmem),
        .e_m2reg(e_m2reg), .e_stall(e_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        useimm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b,
                         input logic setcond, input logic [3:0] jmp);
        @(posedge clk); #1;
        d_aluc = aluc; ra_val = a; rb_val = b; d_useimm = 1'b0;
        d_setcond = setcond; d_jmp = jmp; d_wreg = 1'b1; d_wmem = 1'b0;
    endtask

    // Start a multi-cycle op, count stall cycles, check the DONE-cycle result
    task automatic md_op(input string name, input logic [3:0] aluc, input logic [31:0] a,
                         input logic [31:0] b, input logic setcond,
                         input logic [31:0] exp, input int exp_stalls);
        int stalls = 0;
        logic wreg_bad = 1'b0;
        drive(aluc, a, b, setcond, 4'hF);
        @(negedge clk);
        while (e_stall && stalls < 200) begin
            stalls++;
            if (e_wreg !== 1'b0) wreg_bad = 1'b1;
            if (stalls == 2) begin
                ra_val = 32'hDEAD_BEEF;
                rb_val = 32'h0000_0003;
            end
            @(negedge clk);
        end
        chk({name, "_stalls"}, stalls, exp_stalls);
        chk({name, "_wreg_stall"}, {31'd0, wreg_bad}, 32'd0);
        chk({name, "_result"}, e_result, exp);
        chk({name, "_wreg_done"}, {31'd0, e_wreg}, 32'd1);
    endtask

    task automatic cnd(input string name, input logic [3:0] jmp, input logic exp);
        d_jmp = jmp; #1;
        chk(name, {31'd0, e_cnd}, {31'd0, exp});
    endtask

    initial begin
        tbl[0]  = '{4'h0, 32'd5,          32'd7,          32'd0,          1'b0, 32'd12};
        tbl[1]  = '{4'h1, 32'd3,          32'd5,          32'd0,          1'b0, 32'hFFFF_FFFE};
        tbl[2]  = '{4'h2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,          1'b0, 32'h00F0_00F0};
        tbl[3]  = '{4'h3, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'd0,          1'b0, 32'hF00F_F00F};
        tbl[4]  = '{4'h4, 32'h1234_0000,  32'h0000_5678,  32'd0,          1'b0, 32'h1234_5678};
        tbl[5]  = '{4'h5, 32'd1,          32'd31,         32'd0,          1'b0, 32'h8000_0000};
        tbl[6]  = '{4'h6, 32'h8000_0000,  32'd4,          32'd0,          1'b0, 32'h0800_0000};
        tbl[7]  = '{4'h7, 32'h8000_0000,  32'd4,          32'd0,          1'b0, 32'hF800_0000};
        tbl[8]  = '{4'h5, 32'd3,          32'h25,         32'd0,          1'b0, 32'h0000_0060};
        tbl[9]  = '{4'hB, 32'd5,          32'd7,          32'd0,          1'b0, 32'd0};
        tbl[10] = '{4'hF, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 32'd0};
        tbl[11] = '{4'h0, 32'd10,         32'd99,         32'hFFFF_FFFF,  1'b1, 32'd9};
        tbl[12] = '{4'h7, 32'h7000_0000,  32'd4,          32'd0,          1'b0, 32'h0700_0000};

        reset = 1'b1; e_flush = 1'b0;
        d_aluc = 4'h0; d_jmp = 4'hF; d_imm = 32'd0; ra_val = 32'd0; rb_val = 32'd0;
        d_useimm = 1'b0; d_setcond = 1'b0; d_wreg = 1'b0; d_wmem = 1'b0; d_m2reg = 1'b1;
        d_rn = 5'd17;
        #2;
        chk("reset_stall", {31'd0, e_stall}, 32'd0);
        cnd("reset_E", 4'h3, 1'b1);
        cnd("reset_L", 4'h2, 1'b0);
        cnd("reset_G", 4'h6, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        chk("rn_pass", {27'd0, e_rn}, 32'd17);
        chk("m2reg_pass", {31'd0, e_m2reg}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            d_aluc = tbl[i].aluc; ra_val = tbl[i].a; rb_val = tbl[i].b;
            d_imm = tbl[i].imm; d_useimm = tbl[i].useimm; d_wreg = 1'b1; d_wmem = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_result", i), e_result, tbl[i].exp);
            chk($sformatf("vec%0d_stall", i), {31'd0, e_stall}, 32'd0);
            chk($sformatf("vec%0d_wmem", i), {31'd0, e_wmem}, 32'd1);
            chk($sformatf("vec%0d_store", i), e_store_data, tbl[i].b);
        end
        d_imm = 32'd0; d_useimm = 1'b0; d_wmem = 1'b0;

        // multiply with setcond: flags go ZF=0 SF=0 OF=0 at DONE
        md_op("mul", 4'h8, 32'h0001_0003, 32'h0000_0005, 1'b1, 32'h0005_000F, 33);
        drive(4'h0, 32'd0, 32'd0, 1'b0, 4'hF);
        @(negedge clk);
        cnd("mul_flags_G", 4'h6, 1'b1);
        cnd("mul_flags_LE", 4'h1, 1'b0);

        md_op("divu", 4'h9, 32'd100, 32'd7, 1'b0, 32'd14, 33);
        md_op("remu", 4'hA, 32'd100, 32'd7, 1'b0, 32'd2, 33);
        md_op("divu0", 4'h9, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1);
        md_op("remu0", 4'hA, 32'd5, 32'd0, 1'b0, 32'd5, 1);

        // signed overflow on ADD: SF=1 OF=1 ZF=0
        drive(4'h0, 32'h7FFF_FFFF, 32'd1, 1'b1, 4'hF);
        @(negedge clk);
        chk("addov_result", e_result, 32'h8000_0000);
        drive(4'h0, 32'd0, 32'd0, 1'b0, 4'h2);
        @(negedge clk);
        cnd("addov_L", 4'h2, 1'b0);
        cnd("addov_E", 4'h3, 1'b0);
        cnd("addov_GE", 4'h5, 1'b1);

        // signed overflow on SUB: SF=0 OF=1
        drive(4'h1, 32'h8000_0000, 32'd1, 1'b1, 4'hF);
        @(negedge clk);
        chk("subov_result", e_result, 32'h7FFF_FFFF);
        drive(4'h0, 32'd0, 32'd0, 1'b0, 4'h2);
        @(negedge clk);
        cnd("subov_L", 4'h2, 1'b1);
        cnd("subov_G", 4'h6, 1'b0);

        // equal compare
        drive(4'h1, 32'd3, 32'd3, 1'b1, 4'hF);
        @(negedge clk);
        chk("sub_eq_result", e_result, 32'd0);
        drive(4'h0, 32'd0, 32'd0, 1'b0, 4'h3);
        @(negedge clk);
        cnd("sub_eq_E", 4'h3, 1'b1);
        cnd("sub_eq_F", 4'hF, 1'b1);
        cnd("sub_eq_8", 4'h8, 1'b0);
        cnd("sub_eq_NE", 4'h4, 1'b0);
        cnd("sub_eq_always", 4'h0, 1'b1);

        // flush in RUN cycle 10 of a multiply with setcond
        drive(4'h8, 32'd3, 32'd5, 1'b1, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        chk("flush_pre_stall", {31'd0, e_stall}, 32'd1);
        e_flush = 1'b1; #1;
        chk("flush_stall", {31'd0, e_stall}, 32'd0);
        chk("flush_wreg", {31'd0, e_wreg}, 32'd0);
        drive(4'h0, 32'd4, 32'd5, 1'b0, 4'h3);
        e_flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_stall", {31'd0, e_stall}, 32'd0);
        chk("flush_idle_result", e_result, 32'd9);
        cnd("flush_flags_E", 4'h3, 1'b1);

        // reset during a divide
        drive(4'h1, 32'd1, 32'd2, 1'b1, 4'hF);
        drive(4'h9, 32'd100, 32'd7, 1'b0, 4'h2);
        @(negedge clk);
        cnd("prereset_L", 4'h2, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("prereset_stall", {31'd0, e_stall}, 32'd1);
        reset = 1'b1; #1;
        chk("midreset_stall", {31'd0, e_stall}, 32'd0);
        cnd("midreset_L", 4'h2, 1'b0);
        cnd("midreset_E", 4'h3, 1'b1);
        d_aluc = 4'h0; ra_val = 32'd2; rb_val = 32'd3; d_wreg = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("postreset_result", e_result, 32'd5);
        chk("postreset_stall", {31'd0, e_stall}, 32'd0);
        chk("postreset_wreg", {31'd0, e_wreg}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter MD_CYCLES, default 32: iteration count of the multiply/divide unit.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  reset; asynchronous and active-high.
REQ-005 d_aluc  in  4  ALU op from the decode/execute pipeline register.
REQ-006 d_jmp  in  4  condition code select; 4'hf = no condition (bubble value).
REQ-007 d_imm, ra_val, rb_val  in  XLEN each  immediate and forwarded operands.
REQ-008 d_useimm, d_setcond, d_wreg, d_wmem, d_m2reg  in  1 each  decoded controls.
REQ-009 d_rn  in  5  destination register.
REQ-010 e_flush  in  1  abort current instruction (branch redirect).
REQ-011 e_result  out  XLEN  execute result.
REQ-012 e_store_data  out  XLEN  equals rb_val.
REQ-013 e_cnd  out  1  condition evaluation.
REQ-014 e_rn  out  5; e_wreg, e_wmem, e_m2reg  out  1 each  forwarded controls.
REQ-015 e_stall  out  1  request to hold the decode/execute register and all upstream stages.

Function
REQ-016 opB = d_useimm ? d_imm : rb_val; opA = ra_val.
REQ-017 aluc: 0 ADD, 1 SUB (opA-opB), 2 AND, 3 XOR, 4 OR, 5 SLL, 6 SRL, 7 SRA (shift amount opB[4:0]), 8 MUL low XLEN, 9 DIVU quotient, A REMU remainder, B..F result 0.
REQ-018 Ops 0-7 and B-F are single-cycle and combinational; e_stall=0 for them.
REQ-019 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE with aluc 8/9/A and no e_flush: latch opA/opB, counter=0, go to RUN, e_stall=1.
REQ-021 RUN: one shift-add (MUL) or restoring shift-subtract (DIVU/REMU) step per cycle; e_stall=1; after MD_CYCLES steps go to DONE.
REQ-022 DONE: e_stall=0, e_result=latched product/quotient/remainder; next state IDLE; total latency 2+MD_CYCLES cycles.
REQ-023 DIVU/REMU with opB=0: IDLE goes directly to DONE; quotient all-ones, remainder=opA.
REQ-024 e_flush in any state forces IDLE next cycle and e_stall=0 in that cycle; flags not updated.
REQ-025 Flag register ZF, SF, OF updated from e_result only when d_setcond=1, e_stall=0, e_flush=0.
REQ-026 OF: ADD = operands same sign and result sign differs; SUB = operand signs differ and result sign differs from opA; all other ops 0.
REQ-027 e_cnd from stored flags: 0 always, 1 LE (SF^OF)|ZF, 2 L SF^OF, 3 E ZF, 4 NE ~ZF, 5 GE ~(SF^OF), 6 G ~(SF^OF)&~ZF; 7-E = 0; F = 1.
REQ-028 e_wreg = d_wreg & ~e_stall & ~e_flush; e_wmem likewise; e_rn and e_m2reg pass through.
REQ-029 Operands are captured at start; upstream changes during RUN are ignored.

Reset
REQ-030 Reset: FSM IDLE, counter 0, ZF=1, SF=0, OF=0, e_stall=0; an in-flight multiply/divide is discarded.

Structure
REQ-031 Shared package holds ALU op encodings, condition encodings (incl. COND_NONE=4'hf), and FSM state type.
REQ-032 Multiply/divide iterator is one sub-module, md_unit (start, op, a, b -> busy, done, result); ALU and condition logic stay in exec_stage.

Verification
REQ-033 ADD 0x7FFFFFFF+1 with setcond -> e_result 0x80000000, next cycle SF=1 OF=1 ZF=0; jmp 2 (L) -> e_cnd=0.
REQ-034 MUL 0x0001_0003 x 0x0000_0005 -> e_stall high 33 cycles, DONE cycle e_result 0x0005_000F, e_stall 0.
REQ-035 DIVU 100/7 -> quotient 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF after 1 stall cycle.
REQ-036 e_flush at RUN cycle 10 of MUL -> e_stall 0 that cycle, IDLE next, no flag change, e_wreg 0.
REQ-037 reset asserted mid-DIVU -> e_stall 0 immediately, flags ZF=1 SF=0 OF=0, following ADD completes single-cycle.
REQ-038 SUB 3-3 setcond then jmp 3 (E) -> e_cnd=1; jmp F -> e_cnd=1; jmp 8 -> e_cnd=0.
